ndma_obi_sub_mem: RTL

- OBI subordinate (responder) backed by a word-addressed memory array. It is the far end of the DMA read and write manager ports.
- Instantiated twice in DMA testbenches and subsystem tops: source memory and destination memory.
- Accepts OBI A-channel requests, returns R-channel responses after a fixed latency, and buffers responses under R-channel backpressure.
- Bounds outstanding transactions so no response is ever dropped.

---
 rtl/ndma_obi_sub_mem.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ndma_obi_sub_mem.sv
// OBI subordinate backed by a word-addressed memory, with a fixed-latency response pipe
// and a response FIFO for R-channel backpressure. Optional grant stalls: NDMA_SUB_STALL_EN.
module ndma_obi_sub_mem #(
   parameter int unsigned MemWords       = 256,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned RspLatency     = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [31:0]            addr_i,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic                   rvalid_o,
   input  logic                   rready_i,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   err_o
);

   localparam int unsigned AW = $clog2(MemWords);
   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [32:0] MemBytes = 33'(MemWords) * 33'd4;

   logic [DataWidth-1:0] mem_q [MemWords];
   logic [CW-1:0]        outstanding_q;
   logic                 stall;
   logic                 addr_err;
   logic [AW-1:0]        word_idx;
   logic [DataWidth-1:0] be_mask;
   logic                 in_err;
   logic [DataWidth-1:0] in_data;
   logic                 push_v;
   logic                 push_err;
   logic [DataWidth-1:0] push_data;
   logic                 pop;

   logic [DataWidth-1:0] fifo_data [MaxOutstanding];
   logic                 fifo_err  [MaxOutstanding];
   logic [PW-1:0]        wr_ptr_q;
   logic [PW-1:0]        rd_ptr_q;
   logic [CW-1:0]        fifo_cnt_q;
   logic                 fifo_full;

`ifdef NDMA_SUB_STALL_EN
   logic [7:0] lfsr_q;

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left
   always_ff @(posedge clk_i) begin
      if (!rst_ni) lfsr_q <= 8'hA5;
      else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end
   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Slot check uses the registered count, so a retire frees a slot one cycle later
   assign gnt_o = rst_ni & req_i & ~stall & (outstanding_q < CW'(MaxOutstanding));

   assign word_idx = addr_i[2 +: AW];
   assign addr_err = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= MemBytes);

   always_comb begin
      be_mask = '0;
      for (int k = 0; k < int'(DataWidth / 8); k++) begin
         be_mask[8*k +: 8] = {8{be_i[k]}};
      end
   end

   assign in_err  = addr_err;
   assign in_data = (we_i || addr_err) ? '0 : (mem_q[word_idx] & be_mask);

   always_ff @(posedge clk_i) begin
      if (gnt_o && we_i && !addr_err) begin
         for (int k = 0; k < int'(DataWidth / 8); k++) begin
            if (be_i[k]) mem_q[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
   end

   // RspLatency-1 register stages; the FIFO register supplies the final cycle
   if (RspLatency == 1) begin : g_nopipe
      assign push_v    = gnt_o;
      assign push_err  = in_err;
      assign push_data = in_data;
   end else begin : g_pipe
      logic                 pv_q [RspLatency-1];
      logic                 pe_q [RspLatency-1];
      logic [DataWidth-1:0] pd_q [RspLatency-1];

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            for (int i = 0; i < int'(RspLatency) - 1; i++) pv_q[i] <= 1'b0;
         end else begin
            pv_q[0] <= gnt_o;
            for (int i = 1; i < int'(RspLatency) - 1; i++) pv_q[i] <= pv_q[i-1];
         end
      end

      always_ff @(posedge clk_i) begin
         pe_q[0] <= in_err;
         pd_q[0] <= in_data;
         for (int i = 1; i < int'(RspLatency) - 1; i++) begin
            pe_q[i] <= pe_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
      end

      assign push_v    = pv_q[RspLatency-2];
      assign push_err  = pe_q[RspLatency-2];
      assign push_data = pd_q[RspLatency-2];
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
   endfunction

   assign fifo_full = (fifo_cnt_q == CW'(MaxOutstanding));
   assign rvalid_o  = (fifo_cnt_q != '0);
   assign rdata_o   = rvalid_o ? fifo_data[rd_ptr_q] : '0;
   assign err_o     = rvalid_o ? fifo_err[rd_ptr_q] : 1'b0;
   assign pop       = rvalid_o & rready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push_v) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push_v && !pop)      fifo_cnt_q <= fifo_cnt_q + CW'(1);
         else if (!push_v && pop) fifo_cnt_q <= fifo_cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_v) begin
         fifo_data[wr_ptr_q] <= push_data;
         fifo_err[wr_ptr_q]  <= push_err;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)                 outstanding_q <= '0;
      else if (gnt_o && !pop)      outstanding_q <= outstanding_q + CW'(1);
      else if (!gnt_o && pop)      outstanding_q <= outstanding_q - CW'(1);
   end

`ifndef SYNTHESIS
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_v && fifo_full))
      else $error("response fifo push while full");
`endif

endmodule
